// File: rtl/sb_pkg.sv
// Shared sideband symbol constants, CRC-16 settings and the receive parser state set.
package sb_pkg;

  localparam logic [7:0]  DLE         = 8'hFE;
  localparam logic [7:0]  STX_CMD     = 8'h05;
  localparam logic [7:0]  STX_RSP     = 8'h04;
  localparam logic [7:0]  ETX         = 8'h40;
  localparam logic [7:0]  LSE_DEFAULT = 8'h80;

  localparam logic [15:0] CRC16_POLY  = 16'h8005;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;

  typedef enum logic [3:0] {
    RX_IDLE,
    RX_DLE1,
    RX_CLSE,
    RX_ADDR,
    RX_LEN,
    RX_DATA,
    RX_CRC1,
    RX_CRC2,
    RX_DLE2,
    RX_ETX
  } rx_state_t;

endpackage

// File: rtl/sb_crc16_byte.sv
// One-byte step of CRC-16 (poly 0x8005, MSB-first, unreflected); shared by the SB RX and TX paths.
module sb_crc16_byte
  import sb_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [7:0] data_sh;

  always_comb begin
    crc_out = crc_in;
    data_sh = data;
    for (int unsigned i = 0; i < 8; i++) begin
      if (crc_out[15] ^ data_sh[7]) begin
        crc_out = {crc_out[14:0], 1'b0} ^ CRC16_POLY;
      end else begin
        crc_out = {crc_out[14:0], 1'b0};
      end
      data_sh = {data_sh[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/sb_trans_parser_fsm.sv
// SB receive-side parser: reassembles LT and AT transactions from deserialized symbols and
// reports each decoded transaction (or a framing abort) as a one-cycle pulse.
module sb_trans_parser_fsm
  import sb_pkg::*;
#(
  parameter int unsigned MAX_DATA_BYTES = 3,
  parameter int unsigned TIMEOUT_CYC    = 64
) (
  input  logic                        sb_clk,
  input  logic                        rst,
  input  logic                        rx_en,
  input  logic                        sym_valid,
  input  logic [9:0]                  sym,
  output logic                        rx_busy,
  output logic                        lt_valid,
  output logic [7:0]                  lt_sym,
  output logic                        at_valid,
  output logic                        at_is_rsp,
  output logic [7:0]                  at_addr,
  output logic [7:0]                  at_len,
  output logic [8*MAX_DATA_BYTES-1:0] at_data,
  output logic                        crc_err,
  output logic                        frame_err
);

  localparam int unsigned        DATA_W   = 8 * MAX_DATA_BYTES;
  localparam int unsigned        TMO_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [6:0]         MAX_CNT  = 7'(MAX_DATA_BYTES);

  rx_state_t          state;
  logic [15:0]        crc_q;
  logic [15:0]        crc_nxt;
  logic [15:0]        rx_crc;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [7:0]         lse_q;
  logic               is_rsp_q;
  logic [7:0]         addr_q;
  logic [7:0]         len_q;
  logic [DATA_W-1:0]  data_q;
  logic [6:0]         cnt_q;
  logic [6:0]         idx_q;

  logic               accept;
  logic               sym_ok;
  logic [7:0]         b;
  logic               data_exp;

  assign accept   = sym_valid & rx_en;
  assign sym_ok   = ~sym[0] & sym[9];
  assign b        = sym[8:1];
  // Payload follows the LEN byte for write commands and read responses only.
  assign data_exp = is_rsp_q ? ~b[7] : b[7];
  assign rx_busy  = (state != RX_IDLE);

  sb_crc16_byte u_crc (
    .crc_in  (crc_q),
    .data    (b),
    .crc_out (crc_nxt)
  );

  always_ff @(posedge sb_clk) begin
    if (rst) begin
      state     <= RX_IDLE;
      crc_q     <= CRC16_INIT;
      rx_crc    <= '0;
      tmo_cnt   <= '0;
      lse_q     <= LSE_DEFAULT;
      is_rsp_q  <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      lt_valid  <= 1'b0;
      lt_sym    <= '0;
      at_valid  <= 1'b0;
      at_is_rsp <= 1'b0;
      at_addr   <= '0;
      at_len    <= '0;
      at_data   <= '0;
      crc_err   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      lt_valid  <= 1'b0;
      at_valid  <= 1'b0;
      frame_err <= 1'b0;

      if (!rx_en) begin
        state   <= RX_IDLE;
        tmo_cnt <= '0;
      end else if (accept) begin
        tmo_cnt <= '0;
        if (!sym_ok) begin
          // Line-idle and noise are harmless between frames; inside a frame they abort it.
          if (state != RX_IDLE) begin
            frame_err <= 1'b1;
            state     <= RX_IDLE;
          end
        end else begin
          unique case (state)
            RX_IDLE: begin
              if (b == DLE) begin
                state <= RX_DLE1;
                crc_q <= CRC16_INIT;
              end
            end
            RX_DLE1: begin
              if (b == STX_CMD || b == STX_RSP) begin
                is_rsp_q <= (b == STX_RSP);
                crc_q    <= crc_nxt;
                data_q   <= '0;
                state    <= RX_ADDR;
              end else if (b == DLE) begin
                crc_q <= CRC16_INIT;
              end else if (b[7]) begin
                lse_q <= b;
                state <= RX_CLSE;
              end else begin
                frame_err <= 1'b1;
                state     <= RX_IDLE;
              end
            end
            RX_CLSE: begin
              if (b == ~lse_q) begin
                lt_valid <= 1'b1;
                lt_sym   <= lse_q;
              end else begin
                frame_err <= 1'b1;
              end
              state <= RX_IDLE;
            end
            RX_ADDR: begin
              addr_q <= b;
              crc_q  <= crc_nxt;
              state  <= RX_LEN;
            end
            RX_LEN: begin
              len_q <= b;
              crc_q <= crc_nxt;
              cnt_q <= b[6:0];
              idx_q <= '0;
              if (b[6:0] > MAX_CNT) begin
                frame_err <= 1'b1;
                state     <= RX_IDLE;
              end else if (data_exp && b[6:0] != 7'd0) begin
                state <= RX_DATA;
              end else begin
                state <= RX_CRC1;
              end
            end
            RX_DATA: begin
              for (int unsigned i = 0; i < MAX_DATA_BYTES; i++) begin
                if (idx_q == 7'(i)) data_q[8*i +: 8] <= b;
              end
              crc_q <= crc_nxt;
              idx_q <= idx_q + 7'd1;
              if (idx_q == cnt_q - 7'd1) state <= RX_CRC1;
            end
            RX_CRC1: begin
              rx_crc[15:8] <= b;
              state        <= RX_CRC2;
            end
            RX_CRC2: begin
              rx_crc[7:0] <= b;
              state       <= RX_DLE2;
            end
            RX_DLE2: begin
              if (b == DLE) begin
                state <= RX_ETX;
              end else begin
                frame_err <= 1'b1;
                state     <= RX_IDLE;
              end
            end
            RX_ETX: begin
              if (b == ETX) begin
                at_valid  <= 1'b1;
                at_is_rsp <= is_rsp_q;
                at_addr   <= addr_q;
                at_len    <= len_q;
                at_data   <= data_q;
                crc_err   <= (rx_crc != crc_q);
              end else begin
                frame_err <= 1'b1;
              end
              state <= RX_IDLE;
            end
            default: state <= RX_IDLE;
          endcase
        end
      end else if (state != RX_IDLE) begin
        if (tmo_cnt == TMO_LAST) begin
          frame_err <= 1'b1;
          state     <= RX_IDLE;
          tmo_cnt   <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sb_trans_parser_fsm.sv
// Scoreboard bench for sb_trans_parser_fsm: frames are built from transaction descriptions and the
// expected pulse (kind, cycle, fields) is queued; a negedge monitor pops and compares.
module tb_sb_trans_parser_fsm;

  localparam logic [7:0] DLE_B = 8'hFE;
  localparam logic [7:0] ETX_B = 8'h40;
  localparam int         TMO   = 64;

  logic        sb_clk = 1'b0;
  logic        rst;
  logic        rx_en;
  logic        sym_valid;
  logic [9:0]  sym;
  logic        rx_busy;
  logic        lt_valid;
  logic [7:0]  lt_sym;
  logic        at_valid;
  logic        at_is_rsp;
  logic [7:0]  at_addr;
  logic [7:0]  at_len;
  logic [23:0] at_data;
  logic        crc_err;
  logic        frame_err;

  sb_trans_parser_fsm #(.MAX_DATA_BYTES(3), .TIMEOUT_CYC(TMO)) dut (
    .sb_clk    (sb_clk),
    .rst       (rst),
    .rx_en     (rx_en),
    .sym_valid (sym_valid),
    .sym       (sym),
    .rx_busy   (rx_busy),
    .lt_valid  (lt_valid),
    .lt_sym    (lt_sym),
    .at_valid  (at_valid),
    .at_is_rsp (at_is_rsp),
    .at_addr   (at_addr),
    .at_len    (at_len),
    .at_data   (at_data),
    .crc_err   (crc_err),
    .frame_err (frame_err)
  );

  always #5 sb_clk = ~sb_clk;

  // pv encodes the pulse: bit0 lt_valid, bit1 at_valid, bit2 frame_err
  typedef struct {
    logic [2:0]  pv;
    int          cyc;
    logic [7:0]  lt_sym;
    logic        is_rsp;
    logic [7:0]  addr;
    logic [7:0]  len;
    logic [23:0] data;
    logic        crc_err;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   last_cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge sb_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor
  always @(negedge sb_clk) begin
    logic [2:0] pv;
    exp_t e;
    pv = {frame_err, at_valid, lt_valid};
    if (pv != 3'b000) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'(pv), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", 32'(pv), 32'(e.pv));
        chk("pulse_cycle", cyc, e.cyc);
        if (pv == e.pv && e.pv[0]) begin
          chk("lt_sym", 32'(lt_sym), 32'(e.lt_sym));
        end
        if (pv == e.pv && e.pv[1]) begin
          chk("at_is_rsp", 32'(at_is_rsp), 32'(e.is_rsp));
          chk("at_addr", 32'(at_addr), 32'(e.addr));
          chk("at_len", 32'(at_len), 32'(e.len));
          chk("at_data", 32'(at_data), 32'(e.data));
          chk("crc_err", 32'(crc_err), 32'(e.crc_err));
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      chk("missing_pulse", 32'(pv), 32'(e.pv));
    end
  end

  function automatic logic [15:0] crc16(input logic [7:0] msg[$]);
    logic [15:0] r = 16'hFFFF;
    foreach (msg[i]) begin
      logic [7:0] m = msg[i];
      for (int k = 0; k < 8; k++) begin
        logic fb = r[15] ^ m[7];
        r = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        m = {m[6:0], 1'b0};
      end
    end
    return r;
  endfunction

  task automatic push(input logic [2:0] pv, input int at_cyc, input logic [7:0] ls,
                      input logic rsp, input logic [7:0] a, input logic [7:0] l,
                      input logic [23:0] d, input logic ce);
    exp_t e;
    e.pv = pv; e.cyc = at_cyc; e.lt_sym = ls; e.is_rsp = rsp;
    e.addr = a; e.len = l; e.data = d; e.crc_err = ce;
    exp_q.push_back(e);
  endtask

  task automatic push_lt(input logic [7:0] ls);
    push(3'b001, last_cyc, ls, 1'b0, 8'h0, 8'h0, 24'h0, 1'b0);
  endtask

  task automatic push_fe(input int at_cyc);
    push(3'b100, at_cyc, 8'h0, 1'b0, 8'h0, 8'h0, 24'h0, 1'b0);
  endtask

  task automatic send_sym(input logic [9:0] s);
    sym       = s;
    sym_valid = 1'b1;
    @(posedge sb_clk);
    #1;
    sym_valid = 1'b0;
    sym       = 10'h3FF;
    last_cyc  = cyc;
  endtask

  task automatic send_byte(input logic [7:0] v);
    send_sym({1'b1, v, 1'b0});
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge sb_clk);
      #1;
    end
  endtask

  task automatic send_seq(input logic [7:0] q[$], input int gapmax);
    foreach (q[i]) begin
      if (i > 0 && gapmax > 0) idle($urandom_range(gapmax, 0));
      send_byte(q[i]);
    end
  endtask

  task automatic do_lt(input logic [7:0] lse, input logic good, input int gapmax);
    logic [7:0] q[$];
    logic [7:0] clse;
    clse = good ? ~lse : (~lse ^ 8'($urandom_range(255, 1)));
    q.push_back(DLE_B); q.push_back(lse); q.push_back(clse);
    send_seq(q, gapmax);
    if (good) push_lt(lse);
    else push_fe(last_cyc);
  endtask

  // Builds an AT frame from a transaction description and queues its expected decode.
  task automatic do_at(input logic rsp, input logic wr, input int cnt, input logic [7:0] addr,
                       input logic [23:0] payload, input logic flip, input int gapmax);
    logic [7:0]  body[$];
    logic [7:0]  q[$];
    logic [7:0]  len;
    logic [23:0] exp_d;
    logic [15:0] c;
    len   = {wr, 7'(cnt)};
    exp_d = '0;
    body.push_back(rsp ? 8'h04 : 8'h05);
    body.push_back(addr);
    body.push_back(len);
    if ((!rsp && wr) || (rsp && !wr)) begin
      for (int i = 0; i < cnt; i++) begin
        logic [7:0] d = 8'(payload >> (8 * i));
        body.push_back(d);
        exp_d = exp_d | (24'(d) << (8 * i));
      end
    end
    c = crc16(body);
    if (flip) c = c ^ (16'h1 << $urandom_range(15, 0));
    q.push_back(DLE_B);
    foreach (body[i]) q.push_back(body[i]);
    q.push_back(c[15:8]); q.push_back(c[7:0]); q.push_back(DLE_B); q.push_back(ETX_B);
    send_seq(q, gapmax);
    push(3'b010, last_cyc, 8'h0, rsp, addr, len, exp_d, flip);
  endtask

  initial begin
    logic [7:0]  q[$];
    logic [7:0]  body[$];
    logic [15:0] c;
    rst = 1'b1; rx_en = 1'b1; sym_valid = 1'b0; sym = 10'h3FF;
    repeat (3) @(posedge sb_clk);
    #1;
    chk("reset_busy", 32'(rx_busy), 32'd0);
    chk("reset_lt_sym", 32'(lt_sym), 32'd0);
    chk("reset_at_fields", {at_addr, at_len, 15'd0, at_is_rsp}, 32'd0);
    chk("reset_at_data", 32'(at_data), 32'd0);
    chk("reset_pulses", {29'd0, lt_valid, at_valid, frame_err}, 32'd0);
    rst = 1'b0;
    idle(2);

    do_lt(8'h80, 1'b1, 0);
    do_at(1'b0, 1'b0, 3, 8'h4E, 24'h0, 1'b0, 0);
    do_at(1'b1, 1'b0, 3, 8'h4E, 24'h332211, 1'b0, 0);
    do_at(1'b1, 1'b0, 3, 8'h4E, 24'h332211, 1'b1, 0);

    q = {}; q.push_back(8'hFE); q.push_back(8'h80); q.push_back(8'h7E);
    send_seq(q, 0); push_fe(last_cyc);

    send_byte(8'hFE); send_byte(8'h05);
    send_sym({1'b0, 8'h4E, 1'b0}); push_fe(last_cyc);

    q = {}; q.push_back(8'hFE); q.push_back(8'h05); q.push_back(8'h4E); q.push_back(8'h05);
    send_seq(q, 0); push_fe(last_cyc);

    // timeout after ADDR
    send_byte(8'hFE); send_byte(8'h05); send_byte(8'h4E);
    chk("busy_in_frame", 32'(rx_busy), 32'd1);
    push_fe(last_cyc + TMO);
    idle(TMO + 6);
    chk("busy_after_timeout", 32'(rx_busy), 32'd0);

    // a symbol landing on the expiry cycle keeps the frame alive
    body = {}; body.push_back(8'h05); body.push_back(8'h4E); body.push_back(8'h03);
    c = crc16(body);
    send_byte(8'hFE); send_byte(8'h05); send_byte(8'h4E);
    idle(TMO - 1);
    q = {}; q.push_back(8'h03); q.push_back(c[15:8]); q.push_back(c[7:0]);
    q.push_back(8'hFE); q.push_back(8'h40);
    send_seq(q, 0);
    push(3'b010, last_cyc, 8'h0, 1'b0, 8'h4E, 8'h03, 24'h0, 1'b0);

    repeat (5) send_sym(10'h3FF);
    chk("busy_line_idle", 32'(rx_busy), 32'd0);
    send_byte(8'hFE);
    do_at(1'b0, 1'b1, 2, 8'h12, 24'h00BEEF, 1'b0, 0);

    do_lt(8'h81, 1'b1, 0);
    do_lt(8'hC3, 1'b1, 0);

    // reset mid-frame
    q = {}; q.push_back(8'hFE); q.push_back(8'h05); q.push_back(8'h4E);
    q.push_back(8'h83); q.push_back(8'hAA);
    send_seq(q, 0);
    rst = 1'b1;
    @(posedge sb_clk);
    #1;
    rst = 1'b0;
    chk("busy_after_rst", 32'(rx_busy), 32'd0);
    chk("lt_sym_after_rst", 32'(lt_sym), 32'd0);
    do_lt(8'h90, 1'b1, 0);

    // rx_en drop mid-frame, and symbols offered while disabled
    q = {}; q.push_back(8'hFE); q.push_back(8'h04); q.push_back(8'h4E);
    send_seq(q, 0);
    rx_en = 1'b0;
    @(posedge sb_clk);
    #1;
    chk("busy_after_rx_en_low", 32'(rx_busy), 32'd0);
    send_byte(8'hFE); send_byte(8'h80); send_byte(8'h7F);
    rx_en = 1'b1;
    do_lt(8'hA5, 1'b1, 0);

    for (int n = 0; n < 60; n++) begin
      int unsigned kind = $urandom_range(4, 0);
      logic [7:0] lse;
      do lse = 8'h80 | 8'($urandom_range(127, 0)); while (lse == 8'hFE);
      case (kind)
        0, 1: do_at(1'($urandom), 1'($urandom), int'($urandom_range(3, 0)), 8'($urandom),
                    24'($urandom), ($urandom_range(3, 0) == 0), 2);
        2: do_lt(lse, 1'b1, 2);
        3: do_lt(lse, 1'b0, 2);
        default: begin
          q = {}; q.push_back(8'hFE); q.push_back(1'($urandom) ? 8'h05 : 8'h04);
          q.push_back(8'($urandom));
          q.push_back({1'($urandom), 7'($urandom_range(127, 4))});
          send_seq(q, 2);
          push_fe(last_cyc);
        end
      endcase
      idle(int'($urandom_range(2, 0)));
    end

    idle(5);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
